// File: rtl/pwm_drv_if.sv
// pwm_drv_if: duty/direction command bus from the PID loop to pwm_drv.
//   duty     [DUTY_W] requested duty, unsigned (0 = off, all-ones = maximum)
//   duty_vld          1-cycle strobe; duty and fwd are valid with it
//   fwd               requested direction, 1 = forward
// Modports: master (PID side, drives the bus), slave (pwm_drv side).
interface pwm_drv_if #(
    parameter int unsigned DUTY_W = 12
);
    logic [DUTY_W-1:0] duty;
    logic              duty_vld;
    logic              fwd;

    modport master (output duty, output duty_vld, output fwd);
    modport slave  (input  duty, input  duty_vld, input  fwd);
endinterface

// File: rtl/pwm_drv.sv
// pwm_drv: complementary, dead-time-protected PWM pair for one H-bridge leg.
// Duty/direction commands are double-buffered (pending -> active) and take
// effect only at a PWM period boundary, so pulses are never truncated.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   cmd       pwm_drv_if.slave: duty[CNT_W], duty_vld, fwd
//   brake     level; forces the low-side FET on after the dead time
//   pwm_hi    high-side gate drive (registered)
//   pwm_lo    low-side gate drive (registered)
//   dir       direction to the bridge (registered, updates at period start)
//   prd_strt  1-cycle pulse while the PWM counter is 0 (registered)
//
// Optional feature: define PWM_MIN_PULSE_EN to clamp the duty loaded into
// the active register so no high-side pulse or low-side gap is shorter than
// DEAD_CYC (duty < 2*DEAD_CYC -> 0, duty > max - 2*DEAD_CYC -> max).
module pwm_drv #(
    parameter int unsigned DEAD_CYC = 8,   // legal range 1..63
    parameter int unsigned CNT_W    = 12
) (
    input  logic       clk,
    input  logic       rst,
    pwm_drv_if.slave   cmd,
    input  logic       brake,
    output logic       pwm_hi,
    output logic       pwm_lo,
    output logic       dir,
    output logic       prd_strt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [5:0]       DEAD_LD = 6'(DEAD_CYC - 1);
`ifdef PWM_MIN_PULSE_EN
    localparam logic [CNT_W-1:0] MIN_PULSE = CNT_W'(2 * DEAD_CYC);
    localparam logic [CNT_W-1:0] MAX_PULSE = CNT_MAX - MIN_PULSE;
`endif

    typedef enum logic [1:0] {
        LO,
        DEAD_UP,
        HI,
        DEAD_DN
    } state_t;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] duty_p;
    logic [CNT_W-1:0] duty_a;
    logic [CNT_W-1:0] duty_ld;
    logic [CNT_W-1:0] duty_nxt;
    logic             fwd_p;
    logic             fwd_a;
    logic             period_end;
    logic             raw;

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       dcnt;
    logic [5:0]       dcnt_nxt;

    // ------------------------------------------------------------------
    // Counter and double-buffered command registers
    // ------------------------------------------------------------------
    assign cnt_nxt    = cnt + CNT_W'(1);
    assign period_end = (cnt == CNT_MAX);

    // Value transferred pending -> active at the period boundary.
    always_comb begin
        duty_ld = duty_p;
`ifdef PWM_MIN_PULSE_EN
        if (duty_p < MIN_PULSE) begin
            duty_ld = '0;
        end else if (duty_p > MAX_PULSE) begin
            duty_ld = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            duty_p   <= '0;
            duty_a   <= '0;
            fwd_p    <= 1'b1;
            fwd_a    <= 1'b1;
            prd_strt <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (cmd.duty_vld) begin
                duty_p <= cmd.duty;
                fwd_p  <= cmd.fwd;
            end
            // A strobe on this same cycle lands in pending only; active
            // takes the previous pending value.
            if (period_end) begin
                duty_a <= duty_ld;
                fwd_a  <= fwd_p;
            end
            // Registered look-ahead of cnt==0. The cnt==0 cycle directly
            // after reset is not flagged; the first pulse marks the first wrap.
            prd_strt <= period_end;
        end
    end

    assign dir = fwd_a;

    // ------------------------------------------------------------------
    // PWM compare, evaluated for the counter value about to be entered so
    // that the registered FSM state lines up with cnt (raw(c) = c < duty).
    // ------------------------------------------------------------------
    assign duty_nxt = period_end ? duty_ld : duty_a;
    assign raw      = (cnt_nxt < duty_nxt);

    // ------------------------------------------------------------------
    // Dead-time FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= DEAD_DN;
            dcnt   <= DEAD_LD;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            state  <= state_nxt;
            dcnt   <= dcnt_nxt;
            pwm_hi <= (state_nxt == HI);
            pwm_lo <= (state_nxt == LO);
        end
    end

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        case (state)
            LO: begin
                if (raw && !brake) begin
                    state_nxt = DEAD_UP;
                    dcnt_nxt  = DEAD_LD;
                end
            end
            DEAD_UP: begin
                dcnt_nxt = dcnt - 6'd1;
                // Low side switched off cleanly, so aborting back to LO
                // needs no extra dead time.
                if (!raw || brake) begin
                    state_nxt = LO;
                end else if (dcnt == 6'd0) begin
                    state_nxt = HI;
                end
            end
            HI: begin
                if (!raw || brake) begin
                    state_nxt = DEAD_DN;
                    dcnt_nxt  = DEAD_LD;
                end
            end
            DEAD_DN: begin
                dcnt_nxt = dcnt - 6'd1;
                if (dcnt == 6'd0) begin
                    state_nxt = LO;
                end
            end
            default: begin
                state_nxt = DEAD_DN;
                dcnt_nxt  = DEAD_LD;
            end
        endcase
    end

endmodule
